// File: rtl/tt_autosym_probe.sv
// Truth-table capture stage for an N-input boolean function, followed by an exhaustive
// autosymmetry scan that reports the linear space L_f, its size and its degree.
module tt_autosym_probe #(
    parameter int N = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N-1:0]     x_out,
    input  logic             y_in,
    output logic             busy,
    output logic             done,
    output logic [(1<<N)-1:0] tt,
    output logic [(1<<N)-1:0] ls_mask,
    output logic [N:0]       ls_size,
    output logic [3:0]       k_out,
    output logic             ls_err,
    output logic [1:0]       state_dbg
);

    localparam int T = 1 << N;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_SCAN    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   idx_q, idx_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   x_q, x_d;
    logic           eq_q, eq_d;
    logic [T-1:0]   tt_q, tt_d;
    logic [T-1:0]   mask_q, mask_d;
    logic [N:0]     size_q, size_d;
    logic [3:0]     k_q, k_d;
    logic           err_q, err_d;
    logic           eq_cur;

    function automatic logic [3:0] floor_log2(input logic [N:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i <= N; i++) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            x_q     <= '0;
            eq_q    <= 1'b0;
            tt_q    <= '0;
            mask_q  <= '0;
            size_q  <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            x_q     <= x_d;
            eq_q    <= eq_d;
            tt_q    <= tt_d;
            mask_q  <= mask_d;
            size_q  <= size_d;
            k_q     <= k_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_CAPTURE;
            S_CAPTURE: if (&idx_q) state_d = S_SCAN;
            S_SCAN:    if ((&a_q) && (&x_q)) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // The running AND restarts at x = 0 so each shift a is judged on its own sweep.
    assign eq_cur = ((x_q == '0) ? 1'b1 : eq_q) & (tt_q[x_q] == tt_q[x_q ^ a_q]);

    // Datapath next values
    always_comb begin
        idx_d  = idx_q;
        a_d    = a_q;
        x_d    = x_q;
        eq_d   = eq_q;
        tt_d   = tt_q;
        mask_d = mask_q;
        size_d = size_q;
        k_d    = k_q;
        err_d  = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d = '0;
                    size_d = '0;
                    idx_d  = '0;
                    k_d    = '0;
                    err_d  = 1'b0;
                end
            end
            S_CAPTURE: begin
                tt_d[idx_q] = y_in;
                idx_d       = idx_q + N'(1);
                if (&idx_q) begin
                    // a = 0 is trivially in L_f, so the scan starts at a = 1.
                    mask_d[0] = 1'b1;
                    size_d    = (N+1)'(1);
                    a_d       = N'(1);
                    x_d       = '0;
                end
            end
            S_SCAN: begin
                x_d  = x_q + N'(1);
                eq_d = eq_cur;
                if (&x_q) begin
                    mask_d[a_q] = eq_cur;
                    size_d      = size_q + {{N{1'b0}}, eq_cur};
                    a_d         = a_q + N'(1);
                    if (&a_q) begin
                        // Degree and sanity flag are ready in the same cycle as done.
                        k_d   = floor_log2(size_d);
                        err_d = ((size_d & (size_d - (N+1)'(1))) != '0);
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        x_out = '0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            S_CAPTURE: begin
                x_out = idx_q;
                busy  = 1'b1;
            end
            S_SCAN:  busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign tt        = tt_q;
    assign ls_mask   = mask_q;
    assign ls_size   = size_q;
    assign k_out     = k_q;
    assign ls_err    = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_tt_autosym_probe.sv
// Bench for tt_autosym_probe: directed functions, mid-run reset, ignored start pulses and
// random functions, all checked against a direct evaluation of the L_f definition.
module tb_tt_autosym_probe;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  x_out;
  logic        y_in;
  logic        busy;
  logic        done;
  logic [63:0] tt;
  logic [63:0] ls_mask;
  logic [6:0]  ls_size;
  logic [3:0]  k_out;
  logic        ls_err;
  logic [1:0]  state_dbg;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          mode   = 0;
  logic [63:0] rnd_tbl = '0;

  tt_autosym_probe #(.N(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x_out     (x_out),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .tt        (tt),
    .ls_mask   (ls_mask),
    .ls_size   (ls_size),
    .k_out     (k_out),
    .ls_err    (ls_err),
    .state_dbg (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // combinational function under test
  always_comb begin
    case (mode)
      0:       y_in = 1'b0;
      1:       y_in = x_out[0];
      2:       y_in = &x_out;
      3:       y_in = x_out[0] ^ x_out[1];
      default: y_in = rnd_tbl[x_out];
    endcase
  end

  // reference model: evaluate f on every input, then test every shift a against the definition
  function automatic logic [63:0] model_tt(input int m, input logic [63:0] tbl);
    logic [63:0] r;
    logic [5:0]  xv;
    for (int i = 0; i < 64; i++) begin
      xv = 6'(i);
      case (m)
        0:       r[i] = 1'b0;
        1:       r[i] = xv[0];
        2:       r[i] = (i == 63);
        3:       r[i] = xv[0] ^ xv[1];
        default: r[i] = tbl[i];
      endcase
    end
    return r;
  endfunction

  function automatic logic [63:0] model_mask(input logic [63:0] f);
    logic [63:0] r;
    for (int a = 0; a < 64; a++) begin
      r[a] = 1'b1;
      for (int x = 0; x < 64; x++) begin
        if (f[x] != f[x ^ a]) r[a] = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] model_k(input int sz);
    int k;
    k = 0;
    while ((1 << (k + 1)) <= sz) k++;
    return 4'(k);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: start a run, optionally poke start while busy, return edges from start to done
  task automatic do_run(input bit pulse_busy, output int lat);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 5000) begin
      if (pulse_busy) start = (lat == 100) || (lat == 2000) || (lat == 4000);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string name, input int lat, input logic [63:0] exp_tt);
    logic [63:0] exp_mask;
    int          exp_size;
    exp_mask = model_mask(exp_tt);
    exp_size = $countones(exp_mask);
    chk({name, "_latency"}, 64'(lat), 64'd4096);
    chk({name, "_done"},    64'(done), 64'd1);
    chk({name, "_busy"},    64'(busy), 64'd0);
    chk({name, "_tt"},      tt, exp_tt);
    chk({name, "_mask"},    ls_mask, exp_mask);
    chk({name, "_size"},    64'(ls_size), 64'(exp_size));
    chk({name, "_k"},       64'(k_out), 64'(model_k(exp_size)));
    chk({name, "_err"},     64'(ls_err), 64'd0);
    // start in the DONE cycle must be dropped
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_done_pulse"}, 64'(done), 64'd0);
    chk({name, "_idle_state"}, 64'(state_dbg), 64'd0);
    repeat (3) @(negedge clk);
    chk({name, "_no_queue"}, 64'(busy), 64'd0);
    chk({name, "_hold_mask"}, ls_mask, exp_mask);
  endtask

  initial begin
    int          lat;
    logic [63:0] base;
    logic [5:0]  keep;

    // reset
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 64'(state_dbg), 64'd0);
    chk("rst_x_out", 64'(x_out), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_done",  64'(done), 64'd0);
    chk("rst_tt",    tt, 64'd0);
    chk("rst_mask",  ls_mask, 64'd0);
    chk("rst_size",  64'(ls_size), 64'd0);
    chk("rst_k",     64'(k_out), 64'd0);
    chk("rst_err",   64'(ls_err), 64'd0);
    rst = 1'b0;

    // constant zero
    mode = 0;
    do_run(1'b0, lat);
    chk("zero_mask_spec", ls_mask, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("zero_k_spec", 64'(k_out), 64'd6);
    check_run("zero", lat, model_tt(0, '0));

    // x0
    mode = 1;
    do_run(1'b0, lat);
    chk("x0_tt_spec", tt, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("x0_mask_spec", ls_mask, 64'h5555_5555_5555_5555);
    check_run("x0", lat, model_tt(1, '0));

    // AND of all inputs
    mode = 2;
    do_run(1'b0, lat);
    chk("and_tt_spec", tt, 64'h8000_0000_0000_0000);
    chk("and_mask_spec", ls_mask, 64'h1);
    check_run("and", lat, model_tt(2, '0));

    // x0 ^ x1
    mode = 3;
    do_run(1'b0, lat);
    chk("xor_mask_spec", ls_mask, 64'h9999_9999_9999_9999);
    chk("xor_size_spec", 64'(ls_size), 64'd32);
    check_run("xor", lat, model_tt(3, '0));

    // reset in the middle of the scan
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (500) @(negedge clk);
    chk("mid_in_scan", 64'(state_dbg), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy",  64'(busy), 64'd0);
    chk("mid_rst_state", 64'(state_dbg), 64'd0);
    chk("mid_rst_tt",    tt, 64'd0);
    chk("mid_rst_mask",  ls_mask, 64'd0);
    chk("mid_rst_size",  64'(ls_size), 64'd0);
    chk("mid_rst_k",     64'(k_out), 64'd0);
    chk("mid_rst_x_out", 64'(x_out), 64'd0);

    // restart with start pulses while busy
    do_run(1'b1, lat);
    check_run("restart", lat, model_tt(3, '0));

    // random functions; odd runs depend only on a random subset of inputs
    mode = 4;
    for (int r = 0; r < 10; r++) begin
      base = {$urandom, $urandom};
      if (r % 2 == 0) begin
        rnd_tbl = base;
      end else begin
        keep = 6'($urandom_range(0, 63));
        for (int i = 0; i < 64; i++) rnd_tbl[i] = base[6'(i) & keep];
      end
      do_run(1'b0, lat);
      check_run($sformatf("rnd%0d", r), lat, model_tt(4, rnd_tbl));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
